// File: rtl/led_pkg.sv
// Shared LED frame definitions: word layout, header constant and RGB-to-word packing.
// Used by the frame builder and the serial transmitter side.
package led_pkg;

  localparam logic [2:0] LED_HDR    = 3'b111;
  localparam int         LED_WORD_W = 32;

  typedef struct packed {
    logic [2:0] hdr;
    logic [4:0] bright;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } led_word_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } build_state_t;

  // rgb arrives as {R, G, B}; the wire order is B, G, R after the header
  function automatic led_word_t pack_led(input logic [23:0] rgb, input logic [4:0] bright);
    led_word_t w;
    w.hdr    = LED_HDR;
    w.bright = bright;
    w.b      = rgb[7:0];
    w.g      = rgb[15:8];
    w.r      = rgb[23:16];
    return w;
  endfunction

endpackage

// File: rtl/led_frame_builder_if.sv
// Pixel input handshake and packed frame output of the LED frame builder.
// master = pixel source / frame consumer side, slave = the builder.
interface led_frame_builder_if
  import led_pkg::*;
#(
  parameter int LED_NUM = 4
);

  logic                         pix_valid;
  logic                         pix_ready;
  logic [23:0]                  pix_data;
  logic                         pix_sof;
  logic [4:0]                   bright_in;
  logic                         bright_we;
  logic [LED_NUM*LED_WORD_W-1:0] frame_data;
  logic                         frame_en;
  logic [15:0]                  frame_cnt;
  logic                         sof_err;

  modport master (
    output pix_valid, pix_data, pix_sof, bright_in, bright_we,
    input  pix_ready, frame_data, frame_en, frame_cnt, sof_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, bright_in, bright_we,
    output pix_ready, frame_data, frame_en, frame_cnt, sof_err
  );

endinterface

// File: rtl/led_gap_timer.sv
// Saturating cycle counter enforcing the minimum spacing between frame pulses.
// Starts saturated out of reset so the first frame is never delayed; clr restarts the count.
module led_gap_timer #(
  parameter int GAP_CYC = 2048
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic gap_done
);

  localparam int             CW      = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0]  GAP_MAX = CW'(GAP_CYC);

  logic [CW-1:0] gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= GAP_MAX;
    end else if (clr) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + CW'(1);
    end
  end

  assign gap_done = (gap_cnt == GAP_MAX);

endmodule

// File: rtl/led_frame_builder.sv
// Packs RGB pixels into LED words, assembles LED_NUM of them and publishes the bus with a
// one-cycle frame_en pulse; pix_ready drops while a completed frame waits out the gap timer.
module led_frame_builder
  import led_pkg::*;
#(
  parameter int         LED_NUM        = 4,
  parameter int         GAP_CYC        = 2048,
  parameter logic [4:0] BRIGHT_DEFAULT = 5'h1F
) (
  input logic                clk,
  input logic                rst,
  led_frame_builder_if.slave bus
);

  localparam int                IDX_W    = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int                BUS_W    = LED_NUM * LED_WORD_W;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LED_NUM - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = (LED_NUM > 1) ? IDX_W'(1) : '0;

  build_state_t     state;
  build_state_t     state_nxt;
  logic             armed;
  logic             accept;
  logic             sof_restart;
  logic             last_slot;
  logic             gap_done;
  logic             fire;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [4:0]       bright;
  led_word_t        slots [LED_NUM];
  logic [BUS_W-1:0] asm_buf;
  logic [BUS_W-1:0] frame_q;
  logic             frame_en_q;
  logic [15:0]      frame_cnt_q;
  logic             sof_err_q;

  assign accept      = bus.pix_valid & bus.pix_ready;
  assign sof_restart = accept & bus.pix_sof & (idx != '0);
  assign last_slot   = (idx == IDX_LAST);
  assign fire        = (state == ST_HOLD) & gap_done;
  assign wr_idx      = sof_restart ? '0 : idx;

  led_gap_timer #(
    .GAP_CYC (GAP_CYC)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clr      (fire),
    .gap_done (gap_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // A mid-frame sof restarts at slot 0, so it can only complete a frame when LED_NUM==1
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: begin
        if (accept && (sof_restart ? (LED_NUM == 1) : last_slot)) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (gap_done) begin
          state_nxt = ST_COLLECT;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    bus.pix_ready  = armed & (state == ST_COLLECT);
    bus.frame_data = frame_q;
    bus.frame_en   = frame_en_q;
    bus.frame_cnt  = frame_cnt_q;
    bus.sof_err    = sof_err_q;
  end

  always_comb begin
    idx_nxt = idx;
    if (accept) begin
      if (sof_restart) begin
        idx_nxt = IDX_ONE;
      end else if (last_slot) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end
  end

  // Slot 0 sits in the MSBs so it leaves the transmitter first
  always_comb begin
    asm_buf = '0;
    for (int k = 0; k < LED_NUM; k++) begin
      asm_buf[(LED_NUM-k)*LED_WORD_W-1 -: LED_WORD_W] = slots[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      idx         <= '0;
      bright      <= BRIGHT_DEFAULT;
      frame_q     <= '0;
      frame_en_q  <= 1'b0;
      frame_cnt_q <= '0;
      sof_err_q   <= 1'b0;
      for (int k = 0; k < LED_NUM; k++) begin
        slots[k] <= '0;
      end
    end else begin
      armed      <= 1'b1;
      idx        <= idx_nxt;
      frame_en_q <= fire;
      sof_err_q  <= sof_restart;
      if (bus.bright_we) begin
        bright <= bus.bright_in;
      end
      if (accept) begin
        slots[wr_idx] <= pack_led(bus.pix_data, bright);
      end
      if (fire) begin
        frame_q     <= asm_buf;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_builder.sv
// Bench for led_frame_builder: directed scenarios plus random traffic against a frame-level
// reference model that predicts words, frame contents, pulse timing and pix_ready.
module tb_led_frame_builder;

  localparam int LED_NUM = 4;
  localparam int GAP_CYC = 2048;
  localparam int BW      = LED_NUM * 32;
  localparam int LIMIT   = 3 * GAP_CYC;

  logic clk;
  logic rst;

  led_frame_builder_if #(.LED_NUM(LED_NUM)) bus ();

  led_frame_builder #(
    .LED_NUM        (LED_NUM),
    .GAP_CYC        (GAP_CYC),
    .BRIGHT_DEFAULT (5'h1F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [BW-1:0] exp_q[$];
  int            done_q[$];
  int            fire_cyc[$];
  logic [BW-1:0] cur_frame;
  int            cur_n;
  int            pushed;
  logic [4:0]    model_bright;
  logic [BW-1:0] model_bus;
  logic [15:0]   model_cnt;
  bit            have_fire;
  int            last_fire;
  int            cyc;

  function automatic logic [31:0] mk_word(input logic [23:0] d, input logic [4:0] br);
    return {3'b111, br, d[7:0], d[15:8], d[23:16]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    done_q.delete();
    cur_frame    = '0;
    cur_n        = 0;
    model_bright = 5'h1F;
    model_bus    = '0;
    model_cnt    = '0;
    have_fire    = 1'b0;
  endtask

  // Frame leaves at max(completion + 1, previous pulse + GAP_CYC + 1)
  always begin
    int  due;
    bit  exp_fire;
    @(negedge clk);
    #1;
    cyc++;
    if (!rst) begin
      exp_fire = 1'b0;
      if (exp_q.size() != 0) begin
        due = done_q[0] + 1;
        if (have_fire && (last_fire + GAP_CYC + 1 > due)) due = last_fire + GAP_CYC + 1;
        exp_fire = (cyc == due);
      end
      check("frame_en", bus.frame_en, exp_fire);
      if (bus.frame_en) fire_cyc.push_back(cyc);
      if (exp_fire) begin
        model_bus = exp_q.pop_front();
        void'(done_q.pop_front());
        model_cnt = model_cnt + 16'd1;
        last_fire = cyc;
        have_fire = 1'b1;
        check("frame_cnt", bus.frame_cnt, model_cnt);
      end
      check("pix_ready", bus.pix_ready, !((exp_q.size() != 0) && !exp_fire));
      check("frame_data", bus.frame_data, model_bus);
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge
  task automatic send_pix(input logic [23:0] d, input logic sof, input logic bw, input logic [4:0] bi);
    int          guard;
    logic [31:0] word;
    bit          mid;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    bus.bright_we = 1'b0;
    guard = 0;
    while (!bus.pix_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.pix_ready) begin
      check("pix_ready_wait", bus.pix_ready, 1'b1);
      bus.pix_valid = 1'b0;
      return;
    end
    bus.bright_we = bw;
    bus.bright_in = bi;
    word = mk_word(d, model_bright);
    mid  = sof && (cur_n != 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.bright_we = 1'b0;
    if (bw) model_bright = bi;
    if (mid) begin
      cur_n     = 0;
      cur_frame = '0;
    end
    cur_frame = (cur_frame << 32) | BW'(word);
    cur_n++;
    if (cur_n == LED_NUM) begin
      exp_q.push_back(cur_frame);
      done_q.push_back(cyc + 1);
      pushed++;
      cur_n     = 0;
      cur_frame = '0;
    end
    check("sof_err", bus.sof_err, mid);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < LIMIT) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [BW-1:0] fd;
    int            n_fire;
    logic [23:0]   tbl1 [4];
    cyc    = 0;
    pushed = 0;
    rst    = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_sof   = 1'b0;
    bus.bright_in = '0;
    bus.bright_we = 1'b0;
    model_reset();
    #1;
    check("rst_frame_data", bus.frame_data, '0);
    check("rst_frame_en", bus.frame_en, 1'b0);
    check("rst_frame_cnt", bus.frame_cnt, '0);
    check("rst_sof_err", bus.sof_err, 1'b0);
    check("rst_pix_ready", bus.pix_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("ready_before_edge", bus.pix_ready, 1'b0);
    @(negedge clk);
    check("ready_after_edge", bus.pix_ready, 1'b1);

    // first frame, default brightness, fires one cycle after the last accept
    tbl1[0] = 24'h112233; tbl1[1] = 24'h445566; tbl1[2] = 24'h778899; tbl1[3] = 24'hAABBCC;
    for (int i = 0; i < 4; i++) send_pix(tbl1[i], i == 0, 1'b0, 5'h00);
    @(negedge clk);
    check("t1_frame_en", bus.frame_en, 1'b1);
    check("t1_frame_data", bus.frame_data, 128'hFF332211_FF665544_FF998877_FFCCBBAA);
    check("t1_frame_cnt", bus.frame_cnt, 16'd1);

    // two frames streamed back to back: pulses exactly GAP_CYC+1 apart
    for (int i = 0; i < 8; i++) send_pix(24'h010203 * 24'(i + 1), (i % 4) == 0, 1'b0, 5'h00);
    wait_drain();
    n_fire = fire_cyc.size();
    check("t2_fire_count", n_fire, 3);
    if (n_fire >= 2) check("t2_spacing", fire_cyc[n_fire-1] - fire_cyc[n_fire-2], GAP_CYC + 1);

    // brightness write coincident with pixel 2's accept
    send_pix(24'h102030, 1'b1, 1'b0, 5'h00);
    send_pix(24'h405060, 1'b0, 1'b1, 5'h03);
    send_pix(24'h708090, 1'b0, 1'b0, 5'h00);
    send_pix(24'hA0B0C0, 1'b0, 1'b0, 5'h00);
    wait_drain();
    fd = bus.frame_data;
    check("t3_slot1_hdr", fd[95:88], 8'hFF);
    check("t3_slot2_hdr", fd[63:56], 8'hE3);
    check("t3_slot3_hdr", fd[31:24], 8'hE3);

    // sof on the third pixel restarts the frame
    send_pix(24'h0F0F0F, 1'b1, 1'b0, 5'h00);
    send_pix(24'hF0F0F0, 1'b0, 1'b0, 5'h00);
    send_pix(24'hA1B2C3, 1'b1, 1'b0, 5'h00);
    send_pix(24'h111111, 1'b0, 1'b0, 5'h00);
    send_pix(24'h222222, 1'b0, 1'b0, 5'h00);
    send_pix(24'h333333, 1'b0, 1'b0, 5'h00);
    wait_drain();
    fd = bus.frame_data;
    check("t4_slot0", fd[127:96], 32'hE3C3B2A1);
    check("t4_slot3", fd[31:0], 32'hE3333333);

    // reset mid-frame: outputs clear at once, next frame goes out without waiting on the gap
    send_pix(24'h123456, 1'b1, 1'b0, 5'h00);
    send_pix(24'h654321, 1'b0, 1'b0, 5'h00);
    #2 rst = 1'b1;
    #1;
    check("t5_frame_data", bus.frame_data, '0);
    check("t5_frame_cnt", bus.frame_cnt, '0);
    check("t5_pix_ready", bus.pix_ready, 1'b0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_pix(24'h00AA00 + 24'(i), i == 0, 1'b0, 5'h00);
    n_fire = fire_cyc.size();
    wait_drain();
    check("t5_immediate_fire", fire_cyc.size(), n_fire + 1);
    check("t5_cnt_after", bus.frame_cnt, 16'd1);

    // random traffic: ~50% valid, occasional brightness writes and stray sof
    begin
      int target;
      target = pushed + 20;
      while (pushed < target) begin
        logic       sof;
        logic       bw;
        while ($urandom_range(0, 1) == 1) @(negedge clk);
        sof = (cur_n == 0) || ($urandom_range(0, 15) == 0);
        bw  = ($urandom_range(0, 7) == 0);
        send_pix(24'($urandom), sof, bw, 5'($urandom_range(0, 31)));
      end
    end
    wait_drain();
    check("final_frame_cnt", bus.frame_cnt, 16'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
